// File: rtl/exu_alu_rf.sv
// Execute/register block: combinational RV64 ALU plus a 2R1W integer register file.
// Latency: ALU result and both read ports are combinational; a write is visible one clk edge later.
// Backpressure: none. Every operation completes in its cycle, so there is no stall path.
//
// Ports:
//   clk, rst               - single clock; synchronous active-high reset clears x1..x31
//   src1, src2, aluop      - ALU operands and op select (00 pass src2, 01 add, 10 sltu, 11 sub)
//   result                 - ALU result
//   raddr1/rdata1          - read port 1 (x0 reads zero)
//   raddr2/rdata2          - read port 2 (x0 reads zero)
//   we, waddr, wdata       - write port (writes to x0 are dropped)
module exu_alu_rf #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    // ALU
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic [1:0]      aluop,
    output logic [XLEN-1:0] result,
    // Register file read ports
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    // Register file write port
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    typedef enum logic [1:0] {
        ALU_PASS = 2'b00,
        ALU_ADD  = 2'b01,
        ALU_SLTU = 2'b10,
        ALU_SUB  = 2'b11
    } aluop_e;

    // ------------------------------------------------------------------
    // ALU: stateless, ignores rst. Add/sub wrap modulo 2^XLEN.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            ltu;

    always_comb begin
        sum  = src1 + src2;
        diff = src1 - src2;
        ltu  = (src1 < src2);
    end

    always_comb begin
        result = src2;
        case (aluop_e'(aluop))
            ALU_PASS: result = src2;
            ALU_ADD:  result = sum;
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, ltu};
            ALU_SUB:  result = diff;
            default:  result = src2;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file. Entry 0 exists only to keep indexing uniform; it is
    // held at zero and never read (read muxes force zero for address 0).
    // ------------------------------------------------------------------
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    // Reset outranks a same-edge write so the write is simply lost.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Reads come straight from the flops: no write-to-read bypass, so a
    // same-cycle write is only seen after the edge.
    always_comb begin
        rdata1 = (raddr1 == '0) ? '0 : regs_q[raddr1];
        rdata2 = (raddr2 == '0) ? '0 : regs_q[raddr2];
    end

endmodule

// File: tb/tb_exu_alu_rf.sv
module tb_exu_alu_rf;

    logic        clk;
    logic        rst;
    logic [63:0] src1;
    logic [63:0] src2;
    logic [1:0]  aluop;
    logic [63:0] result;
    logic [4:0]  raddr1;
    logic [63:0] rdata1;
    logic [4:0]  raddr2;
    logic [63:0] rdata2;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;

    int checks;
    int failures;

    exu_alu_rf dut (
        .clk    (clk),
        .rst    (rst),
        .src1   (src1),
        .src2   (src2),
        .aluop  (aluop),
        .result (result),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } alu_vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Present a write on the falling edge, commit it on the next rising edge.
    task automatic write_reg(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    alu_vec_t vecs [12];

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0]  = '{2'b01, 64'h0000000080000000, 64'hFFFFFFFFFFFFFFFC, 64'h000000007FFFFFFC};
        vecs[1]  = '{2'b01, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 64'h0000000000000000};
        vecs[2]  = '{2'b01, 64'h0000000000000010, 64'h0000000000000020, 64'h0000000000000030};
        vecs[3]  = '{2'b10, 64'h0000000000000005, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001};
        vecs[4]  = '{2'b10, 64'h0000000000000009, 64'h0000000000000009, 64'h0000000000000000};
        vecs[5]  = '{2'b10, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000005, 64'h0000000000000000};
        vecs[6]  = '{2'b10, 64'h0000000000000004, 64'h0000000000000009, 64'h0000000000000001};
        vecs[7]  = '{2'b11, 64'h0000000000000003, 64'h0000000000000005, 64'hFFFFFFFFFFFFFFFE};
        vecs[8]  = '{2'b11, 64'h0000000000000000, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF};
        vecs[9]  = '{2'b11, 64'h1234567800000000, 64'h0000000000000001, 64'h12345677FFFFFFFF};
        vecs[10] = '{2'b00, 64'h0000000000000000, 64'h000000000000ABCD, 64'h000000000000ABCD};
        vecs[11] = '{2'b00, 64'hFFFFFFFFFFFFFFFF, 64'h8000000000000000, 64'h8000000000000000};

        rst    = 1'b1;
        we     = 1'b1;
        waddr  = 5'd5;
        wdata  = 64'hDEAD;
        src1   = '0;
        src2   = '0;
        aluop  = 2'b00;
        raddr1 = '0;
        raddr2 = '0;

        // Reset held two edges while a write is being attempted.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        we  = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("reset_rd1_x%0d", i), rdata1, 64'h0);
            check($sformatf("reset_rd2_x%0d", 31 - i), rdata2, 64'h0);
        end

        // Write/read on both ports at the same address.
        write_reg(5'd10, 64'h1234567887654321);
        raddr1 = 5'd10;
        raddr2 = 5'd10;
        #1;
        check("x10_rd1", rdata1, 64'h1234567887654321);
        check("x10_rd2", rdata2, 64'h1234567887654321);

        // x0 ignores writes.
        write_reg(5'd0, 64'hFFFFFFFFFFFFFFFF);
        raddr1 = 5'd0;
        raddr2 = 5'd10;
        #1;
        check("x0_rd1", rdata1, 64'h0);
        check("x10_after_x0_wr", rdata2, 64'h1234567887654321);

        // No bypass: old value during the write cycle, new value after the edge.
        write_reg(5'd3, 64'd2);
        @(negedge clk);
        raddr1 = 5'd3;
        we     = 1'b1;
        waddr  = 5'd3;
        wdata  = 64'd7;
        #1;
        check("nobypass_before", rdata1, 64'd2);
        @(posedge clk);
        #1;
        we = 1'b0;
        check("nobypass_after", rdata1, 64'd7);

        // Independent ports on different registers.
        raddr1 = 5'd3;
        raddr2 = 5'd10;
        #1;
        check("indep_rd1", rdata1, 64'd7);
        check("indep_rd2", rdata2, 64'h1234567887654321);

        // ALU table.
        for (int i = 0; i < 12; i++) begin
            aluop = vecs[i].op;
            src1  = vecs[i].a;
            src2  = vecs[i].b;
            #1;
            check($sformatf("alu_vec%0d", i), result, vecs[i].exp);
        end

        // Reset mid-run with a same-edge write to x7.
        write_reg(5'd7, 64'h55);
        raddr1 = 5'd7;
        #1;
        check("x7_pre_reset", rdata1, 64'h55);
        @(negedge clk);
        rst   = 1'b1;
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 64'h99;
        aluop = 2'b01;
        src1  = 64'd100;
        src2  = 64'd23;
        #1;
        check("alu_during_rst", result, 64'd123);
        @(posedge clk);
        #1;
        rst = 1'b0;
        we  = 1'b0;
        raddr1 = 5'd7;
        raddr2 = 5'd10;
        #1;
        check("x7_post_reset", rdata1, 64'h0);
        check("x10_post_reset", rdata2, 64'h0);

        // Register file is usable again after reset.
        write_reg(5'd31, 64'hCAFEF00DCAFEF00D);
        raddr2 = 5'd31;
        #1;
        check("x31_after_reset", rdata2, 64'hCAFEF00DCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exu_alu_rf.md
# exu_alu_rf

Combinational 64-bit integer ALU plus a 32-entry × 64-bit RISC-V integer register file, packaged as one execute/register block of the single-cycle RV64 core. The decoder drives register addresses, ALU operands and the ALU opcode. The core consumes the read data, which feeds operand muxes, branch compare, store data and the `a0` halt value. It also consumes the ALU result, used as the add/address/`sltiu` result. Write-back occurs on the rising clock edge that ends each instruction.

## Interface
- `XLEN`, default 64: data width of the ALU and the registers.
- `NREG`, default 32: number of architectural registers. Address width is log2(NREG) = 5.
- `clk`  in  1: the single clock. All state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset, sampled on the `clk` rising edge.
- `src1`  in  XLEN: ALU operand 1 (rs1 value or pc).
- `src2`  in  XLEN: ALU operand 2 (sign-extended immediate).
- `aluop`  in  2: ALU operation select.
- `result`  out  XLEN: ALU result, combinational.
- `raddr1`  in  5: read port 1 address.
- `rdata1`  out  XLEN: read port 1 data, combinational.
- `raddr2`  in  5: read port 2 address.
- `rdata2`  out  XLEN: read port 2 data, combinational.
- `we`  in  1: write enable.
- `waddr`  in  5: write address.
- `wdata`  in  XLEN: write data.

## Operation
- ALU is purely combinational, with no state and unaffected by `rst`.
  - `aluop` = 2'b01: `result` = `src1` + `src2`, modulo 2^64, with carry discarded. Used for addi, jalr and store address.
  - `aluop` = 2'b10: `result` = 1 if `src1` < `src2` as unsigned, else 0, zero-extended to XLEN. Used for sltiu.
  - `aluop` = 2'b11: `result` = `src1` − `src2`, modulo 2^64.
  - `aluop` = 2'b00: `result` = `src2` (pass-through).
- Register file holds registers x1..x31, each XLEN bits.
  - x0 is hard-wired to zero: reads of address 0 always return 0, and writes to address 0 are discarded.
  - Both read ports are asynchronous. `rdataN` = reg[`raddrN`], or 0 when `raddrN` = 0.
  - Write: on a `clk` rising edge with `we` = 1, `rst` = 0 and `waddr` ≠ 0, reg[`waddr`] ← `wdata`.
  - Reset: on a `clk` rising edge with `rst` = 1, x1..x31 are all cleared to 0. Reset has priority over a simultaneous write, so that write is dropped.
  - No write-to-read bypass. During the cycle in which a write is presented, reads of the same address return the old value. The new value is visible right after the edge.
  - The two read ports are independent and may address the same register, giving identical data.

## Timing
- ALU `result` settles in the same cycle as its inputs change (zero latency).
- Read data has zero latency from `raddr`, combinationally.
- Write latency is one edge. Data presented in cycle N is readable from the start of cycle N+1.
- Reset values:
  - `rdata1` and `rdata2` read 0 for every address from the first edge with `rst` = 1 onward.
  - `result` depends only on its inputs and is never reset.
  - Before the first reset edge, register contents are undefined, except that x0 reads 0.
- Asserting `rst` mid-run clears all registers on that edge, regardless of `we`.
- Holding `rst` high for several cycles keeps every register at 0 and ignores all writes.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with `we` = 1, `waddr` = 5, `wdata` = 0xDEAD. Release reset, then sweep `raddr1` and `raddr2` over 0..31. Required: all reads return 0.
- Write/read and x0:
  - Write x10 = 0x1234567887654321, then read with `raddr1` = `raddr2` = 10. Required: both return 0x1234567887654321 on the cycle after the write edge.
  - Write x0 = 0xFFFF_FFFF_FFFF_FFFF. Required: x0 still reads 0.
- No bypass: in the same cycle, `we` = 1, `waddr` = 3, `wdata` = 7 while x3 holds 2 and `raddr1` = 3. Required: `rdata1` = 2 before the edge and 7 after it.
- Add: `aluop` = 01, `src1` = 0x0000000080000000, `src2` = 0xFFFFFFFFFFFFFFFC (−4). Required: `result` = 0x000000007FFFFFFC.
- Add wrap: `src1` = 0xFFFFFFFFFFFFFFFF, `src2` = 1. Required: `result` = 0.
- Sltiu and other ops:
  - `aluop` = 10 with `src1` = 5, `src2` = 0xFFFFFFFFFFFFFFFF. Required: `result` = 1.
  - `aluop` = 10 with `src1` = `src2` = 9. Required: `result` = 0.
  - `aluop` = 11 with `src1` = 3, `src2` = 5. Required: `result` = 0xFFFFFFFFFFFFFFFE.
  - `aluop` = 00 with `src2` = 0xABCD. Required: `result` = 0xABCD.
- Reset mid-run with write: x7 holds 0x55, then one edge with `rst` = 1, `we` = 1, `waddr` = 7, `wdata` = 0x99. Required: x7 reads 0 after that edge.
